// File: rtl/popcnt_pkg.sv
// popcnt_pkg: shared state encoding, chunk width and count-width helper for popcnt_seq
package popcnt_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CHUNK_W = 6;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/popcnt6.sv
// popcnt6: combinational ones-counter for one 6-bit chunk
module popcnt6 (
  input  logic [5:0] d_i,
  output logic [2:0] cnt_o
);
  // sum the six bits
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 6; i++) cnt_o = cnt_o + 3'(d_i[i]);
  end
endmodule

// File: rtl/popcnt_seq.sv
// popcnt_seq: counts ones in a wide word, one 6-bit chunk per cycle through a shared popcnt6
module popcnt_seq
  import popcnt_pkg::*;
#(
  parameter int CHUNKS = 4,
  localparam int W = CHUNK_W * CHUNKS,
  localparam int CW = cnt_w(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [CW-1:0] out_count,
  input  logic          out_ready,
  output logic          busy
);
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  state_t        state_q;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [2:0]    pc;
  popcnt6 u_pc (.d_i(sreg_q[CHUNK_W-1:0]), .cnt_o(pc));
  assign acc_d  = acc_q + CW'(pc);
  assign sreg_d = sreg_q >> CHUNK_W;
  assign idx_d  = idx_q + IW'(1);
  // accept a word, fold in one chunk per RUN cycle, hold the total until taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else
      case (state_q)
        IDLE: if (in_valid) begin
          state_q <= RUN;
          sreg_q  <= in_data;
          acc_q   <= '0;
          idx_q   <= '0;
        end
        RUN: begin
          acc_q  <= acc_d;
          sreg_q <= sreg_d;
          idx_q  <= idx_d;
          if (idx_q == IW'(CHUNKS - 1)) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_count = acc_q;
endmodule

// File: tb/tb_popcnt_seq.sv
// tb_popcnt_seq: directed and randomized checks of popcnt_seq against a bit-counting model
module tb_popcnt_seq;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, busy;
  logic [23:0] in_data = 0;
  logic [4:0]  out_count;
  int          n_tests = 0, n_fail = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  popcnt_seq #(.CHUNKS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_count(out_count),
    .out_ready(out_ready), .busy(busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_pop(input logic [23:0] w);
    int v = int'(w);
    int c = 0;
    while (v != 0) begin
      c += v % 2;
      v /= 2;
    end
    return c;
  endfunction

  // offer one word at the current negedge, then hold the result for stall cycles
  task automatic run_word(input string tag, input logic [23:0] w, input int stall);
    int lat, bz;
    int exp = ref_pop(w);
    in_valid = 1; in_data = w; out_ready = 0;
    check({tag, "_rdy"}, int'(in_ready), 1);
    @(negedge clk);
    in_valid = 0; in_data = 24'($urandom);
    lat = 0; bz = int'(busy);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      bz += int'(busy);
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_cnt"}, int'(out_count), exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_hold_v"}, int'(out_valid), 1);
      check({tag, "_hold_c"}, int'(out_count), exp);
      check({tag, "_hold_rdy"}, int'(in_ready), 0);
    end
    if (stall == 0) check({tag, "_busy_cycles"}, bz, 5);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check({tag, "_idle_rdy"}, int'(in_ready), 1);
    check({tag, "_idle_v"}, int'(out_valid), 0);
    check({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    int a0, a1, t, seen;
    int q[$];
    int acc_n = 0, res_n = 0, guard = 0;
    logic pv = 0, pr = 0, pov = 0, por = 0;
    logic [23:0] pd = 0;
    logic [4:0] pc = 0;
    repeat (2) @(negedge clk);
    check("rst_rdy", int'(in_ready), 1);
    check("rst_v", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt", int'(out_count), 0);
    rst_n = 1;
    @(negedge clk);

    run_word("zero", 24'h000000, 0);
    run_word("ones", 24'hFFFFFF, 0);
    run_word("stall", 24'h03F000, 10);

    // back-to-back with in_valid held high
    out_ready = 1; in_valid = 1; in_data = 24'hA5A5A5; a0 = cyc;
    @(negedge clk);
    in_data = 24'h000001;
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    check("b2b_cnt0", int'(out_count), 12);
    @(negedge clk);
    a1 = cyc;
    check("b2b_rdy", int'(in_ready), 1);
    check("b2b_gap", a1 - a0, 6);
    @(negedge clk);
    in_valid = 0;
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    check("b2b_v1", int'(out_valid), 1);
    check("b2b_cnt1", int'(out_count), 1);
    @(negedge clk);
    out_ready = 0;
    check("b2b_idle", int'(in_ready), 1);

    // async reset during the 2nd RUN cycle aborts the word
    in_valid = 1; in_data = 24'hFFFFFF;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    check("abort_rdy", int'(in_ready), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_cnt", int'(out_count), 0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (8) begin @(negedge clk); seen += int'(out_valid); end
    check("abort_noresult", seen, 0);
    run_word("after_abort", 24'h000003, 0);

    // randomized traffic with random backpressure
    while ((acc_n < 1000 || q.size() > 0) && guard < 60000) begin
      if (pv && pr) begin
        q.push_back(ref_pop(pd));
        acc_n++;
      end
      if (pov && por) begin
        if (q.size() == 0) check("rnd_extra", 1, 0);
        else check("rnd_cnt", int'(pc), q.pop_front());
        res_n++;
      end
      if (pov && !por) begin
        check("rnd_hold_v", int'(out_valid), 1);
        check("rnd_hold_c", int'(out_count), int'(pc));
      end
      in_valid = (acc_n < 1000) && ($urandom_range(3) != 0);
      in_data = 24'($urandom);
      out_ready = 1'($urandom_range(1));
      pv = in_valid; pr = in_ready; pd = in_data;
      pov = out_valid; por = out_ready; pc = out_count;
      @(negedge clk);
      guard++;
    end
    check("rnd_timeout", int'(guard < 60000), 1);
    check("rnd_accepted", acc_n, 1000);
    check("rnd_results", res_n, 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
